frame_sequencer: RTL and testbench

Per-frame controller for the line-drawing engine. It holds a table of up to P_MAX_LINES line segments, written by the host. At the start of each vertical blanking interval it pushes the active segments into the drawer's input FIFOs and then pulses the drawer's clear request, so the drawer clears the screen buffer and renders the whole list. It then waits for the drawer to return to waiting before re-arming, and flags frames it had to skip.

---
 rtl/draw_pkg.sv | 20 ++
 rtl/line_table.sv | 37 +++
 rtl/frame_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the line-drawing engine: sequencer state encoding and default geometry.
package draw_pkg;

    localparam int unsigned DEF_X_COORD_W      = 11;
    localparam int unsigned DEF_Y_COORD_W      = 11;
    localparam int unsigned DEF_SCREEN_H       = 480;
    localparam int unsigned DEF_MAX_LINES      = 16;
    localparam int unsigned DEF_LOG2_MAX_LINES = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_READ       = 3'd2,
        ST_PUSH       = 3'd3,
        ST_CLEAR      = 3'd4,
        ST_WAIT_START = 3'd5,
        ST_WAIT_DONE  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/line_table.sv
// Segment register file: one write port, one registered read port (read-before-write on collision).
module line_table #(
    parameter int unsigned P_DEPTH  = 16,
    parameter int unsigned P_ADDR_W = 4,
    parameter int unsigned P_DATA_W = 44
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr,
    input  logic [P_ADDR_W-1:0] i_wr_addr,
    input  logic [P_DATA_W-1:0] i_wr_data,
    input  logic                i_rd,
    input  logic [P_ADDR_W-1:0] i_rd_addr,
    output logic [P_DATA_W-1:0] o_rd_data
);

    logic [P_DATA_W-1:0] mem_q [P_DEPTH];
    logic [P_DATA_W-1:0] rd_data_q;

    // Table contents are deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_wr && (32'(i_wr_addr) < P_DEPTH)) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_data_q <= '0;
        end else if (i_rd) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: feeds the segment table to the drawer at each vblank, then starts a clear/render.
// Optional frame counter enabled by defining FRAME_SEQ_FRAME_CNT_EN.
module frame_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned P_X_COORD_W      = DEF_X_COORD_W,
    parameter int unsigned P_Y_COORD_W      = DEF_Y_COORD_W,
    parameter int unsigned P_SCREEN_H       = DEF_SCREEN_H,
    parameter int unsigned P_MAX_LINES      = DEF_MAX_LINES,
    parameter int unsigned P_LOG2_MAX_LINES = DEF_LOG2_MAX_LINES
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic [P_LOG2_MAX_LINES:0]   i_num_lines,
    input  logic                        i_tbl_wr,
    input  logic [P_LOG2_MAX_LINES-1:0] i_tbl_addr,
    input  logic [P_X_COORD_W-1:0]      i_tbl_x0,
    input  logic [P_X_COORD_W-1:0]      i_tbl_x1,
    input  logic [P_Y_COORD_W-1:0]      i_tbl_y0,
    input  logic [P_Y_COORD_W-1:0]      i_tbl_y1,
    input  logic [P_Y_COORD_W-1:0]      i_vcounter,
    input  logic                        i_drawer_waiting,
    input  logic                        i_fifo_full,
    output logic [P_X_COORD_W-1:0]      o_x0,
    output logic [P_X_COORD_W-1:0]      o_x1,
    output logic [P_Y_COORD_W-1:0]      o_y0,
    output logic [P_Y_COORD_W-1:0]      o_y1,
    output logic                        o_load_fifo,
    output logic                        o_clear_buffer,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic                        o_overrun,
    output logic                        o_overflow,
    output logic [15:0]                 o_frame_count
);

    localparam int unsigned CNT_W   = P_LOG2_MAX_LINES + 1;
    localparam int unsigned ENTRY_W = 2 * P_X_COORD_W + 2 * P_Y_COORD_W;

    seq_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           n_q, n_d, k_q, k_d;
    logic [P_Y_COORD_W-1:0]     vcnt_q;
    logic [P_X_COORD_W-1:0]     x0_q, x0_d, x1_q, x1_d, rd_x0, rd_x1;
    logic [P_Y_COORD_W-1:0]     y0_q, y0_d, y1_q, y1_d, rd_y0, rd_y1;
    logic                       load_q, load_d, clear_q, clear_d, busy_q, busy_d;
    logic                       done_q, done_d, overrun_q, overrun_d, overflow_q, overflow_d;
    logic                       vstart_c, rd_en_c;
    logic [CNT_W-1:0]           num_clamped_c;
    logic [ENTRY_W-1:0]         rd_data;

    line_table #(
        .P_DEPTH  (P_MAX_LINES),
        .P_ADDR_W (P_LOG2_MAX_LINES),
        .P_DATA_W (ENTRY_W)
    ) u_line_table (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr      (i_tbl_wr),
        .i_wr_addr (i_tbl_addr),
        .i_wr_data ({i_tbl_x0, i_tbl_x1, i_tbl_y0, i_tbl_y1}),
        .i_rd      (rd_en_c),
        .i_rd_addr (k_q[P_LOG2_MAX_LINES-1:0]),
        .o_rd_data (rd_data)
    );

    assign {rd_x0, rd_x1, rd_y0, rd_y1} = rd_data;

    assign vstart_c = (vcnt_q != P_Y_COORD_W'(P_SCREEN_H)) &&
                      (i_vcounter == P_Y_COORD_W'(P_SCREEN_H));
    assign num_clamped_c = (i_num_lines > CNT_W'(P_MAX_LINES)) ? CNT_W'(P_MAX_LINES) : i_num_lines;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        load_d     = 1'b0;
        clear_d    = 1'b0;
        done_d     = 1'b0;
        overflow_d = 1'b0;
        rd_en_c    = 1'b0;
        // A trigger outside ARM means this frame cannot be served.
        overrun_d  = vstart_c && (state_q != ST_ARM);

        case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (vstart_c) begin
                    n_d = num_clamped_c;
                    k_d = '0;
                    if (num_clamped_c == '0) done_d = 1'b1;
                    else                     state_d = ST_READ;
                end
            end
            ST_READ: begin
                rd_en_c = 1'b1;
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (i_fifo_full) begin
                    overflow_d = 1'b1;
                    state_d    = ST_CLEAR;
                end else begin
                    x0_d    = rd_x0;
                    x1_d    = rd_x1;
                    y0_d    = rd_y0;
                    y1_d    = rd_y1;
                    load_d  = 1'b1;
                    k_d     = k_q + CNT_W'(1);
                    state_d = ((k_q + CNT_W'(1)) < n_q) ? ST_READ : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_d = 1'b1;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!i_drawer_waiting) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_drawer_waiting) begin
                    done_d  = 1'b1;
                    state_d = i_enable ? ST_ARM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_ARM);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            vcnt_q     <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            load_q     <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            vcnt_q     <= i_vcounter;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            load_q     <= load_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef FRAME_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Wraps naturally at 2^16.
    always_ff @(posedge i_clk) begin
        if (i_reset)     frame_cnt_q <= '0;
        else if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign o_frame_count = frame_cnt_q;
`else
    assign o_frame_count = '0;
`endif

    assign o_x0           = x0_q;
    assign o_x1           = x1_q;
    assign o_y0           = y0_q;
    assign o_y1           = y1_q;
    assign o_load_fifo    = load_q;
    assign o_clear_buffer = clear_q;
    assign o_busy         = busy_q;
    assign o_frame_done   = done_q;
    assign o_overrun      = overrun_q;
    assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a frame-level model schedules expected pulses by cycle, a monitor checks them.
module tb_frame_sequencer;

    localparam int unsigned XW   = 11;
    localparam int unsigned YW   = 11;
    localparam int unsigned SH   = 480;
    localparam int unsigned MAXL = 16;
    localparam int unsigned LW   = 4;
    localparam int unsigned SW   = 2 * XW + 2 * YW;

    localparam int K_LOAD = 0, K_CLEAR = 1, K_DONE = 2, K_OVF = 3, K_OVR = 4;

    logic          i_clk = 1'b0;
    logic          i_reset, i_enable, i_tbl_wr, i_drawer_waiting, i_fifo_full;
    logic [LW:0]   i_num_lines;
    logic [LW-1:0] i_tbl_addr;
    logic [XW-1:0] i_tbl_x0, i_tbl_x1, o_x0, o_x1;
    logic [YW-1:0] i_tbl_y0, i_tbl_y1, o_y0, o_y1, i_vcounter;
    logic          o_load_fifo, o_clear_buffer, o_busy, o_frame_done, o_overrun, o_overflow;
    logic [15:0]   o_frame_count;

    frame_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_num_lines(i_num_lines),
        .i_tbl_wr(i_tbl_wr), .i_tbl_addr(i_tbl_addr), .i_tbl_x0(i_tbl_x0), .i_tbl_x1(i_tbl_x1),
        .i_tbl_y0(i_tbl_y0), .i_tbl_y1(i_tbl_y1), .i_vcounter(i_vcounter),
        .i_drawer_waiting(i_drawer_waiting), .i_fifo_full(i_fifo_full),
        .o_x0(o_x0), .o_x1(o_x1), .o_y0(o_y0), .o_y1(o_y1), .o_load_fifo(o_load_fifo),
        .o_clear_buffer(o_clear_buffer), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_overrun(o_overrun), .o_overflow(o_overflow), .o_frame_count(o_frame_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int            kind;
        longint        cyc;
        logic [SW-1:0] seg;
        int            cnt;
    } ev_t;

    ev_t           exp_q[$];
    logic [SW-1:0] tbl[MAXL];
    longint        cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            cnt_model = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic int exp_cnt();
`ifdef FRAME_SEQ_FRAME_CNT_EN
        return cnt_model % 65536;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input longint c, input logic [SW-1:0] seg);
        ev_t e;
        e.kind = kind; e.cyc = c; e.seg = seg; e.cnt = exp_cnt();
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse the DUT emits must match the oldest outstanding expectation.
    task automatic mon_ev(input int kind, input logic [SW-1:0] seg);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got unexpected kind=%0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == K_LOAD && e.seg != seg) ||
                (kind == K_DONE && e.cnt != int'(o_frame_count))) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d seg=%h cnt=%0d, expected kind=%0d cyc=%0d seg=%h cnt=%0d",
                         kind, cyc, seg, o_frame_count, e.kind, e.cyc, e.seg, e.cnt);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_overrun)      mon_ev(K_OVR, '0);
            if (o_overflow)     mon_ev(K_OVF, '0);
            if (o_load_fifo)    mon_ev(K_LOAD, {o_x0, o_x1, o_y0, o_y1});
            if (o_clear_buffer) mon_ev(K_CLEAR, '0);
            if (o_frame_done)   mon_ev(K_DONE, '0);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr_tbl(input int addr, input logic [SW-1:0] seg);
        i_tbl_wr   = 1'b1;
        i_tbl_addr = LW'(addr);
        {i_tbl_x0, i_tbl_x1, i_tbl_y0, i_tbl_y1} = seg;
        tbl[addr]  = seg;
        step();
        i_tbl_wr   = 1'b0;
    endtask

    task automatic wr_rand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        wr_tbl($urandom_range(0, MAXL - 1), r[SW-1:0]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_load"}, o_load_fifo, 0);
        chk({tag, "_clear"}, o_clear_buffer, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_pulses"}, {o_frame_done, o_overrun, o_overflow}, 0);
        chk({tag, "_coords"}, {o_x0, o_x1, o_y0, o_y1}, 0);
        chk({tag, "_count"}, o_frame_count, 0);
    endtask

    // One frame, modelled from the timing rules: trigger sampled at edge E, push j at E+2+2j,
    // clear one cycle after the last push, frame_done one cycle after the drawer goes idle.
    task automatic run_frame(input int num, input int full_pct, input int force_j,
                             input bit ovr, input bit drop_en, input int lwait);
        bit     full_at[64];
        int     n;
        longint c, e_cyc, c_clr, d;
        repeat ($urandom_range(0, 3)) wr_rand();
        i_num_lines = (LW + 1)'(num);
        n = (num > int'(MAXL)) ? int'(MAXL) : num;
        for (int i = 0; i < 64; i++) full_at[i] = ($urandom_range(0, 99) < full_pct);
        if (force_j >= 0) for (int j = 0; j < int'(MAXL); j++) full_at[2 + 2 * j] = (j == force_j);

        i_vcounter = YW'(SH);
        c = cyc;
        e_cyc = c + 1;
        if (n == 0) begin
            cnt_model++;
            push_ev(K_DONE, e_cyc, '0);
            step();
            i_vcounter = '0;
            repeat (3) step();
            chk("idle_busy_n0", o_busy, 0);
            chk("drained_n0", exp_q.size(), 0);
            return;
        end

        c_clr = 0;
        for (int j = 0; j < n; j++) begin
            c_clr = e_cyc + 3 + 2 * j;
            if (full_at[2 + 2 * j]) begin
                push_ev(K_OVF, e_cyc + 2 + 2 * j, '0);
                break;
            end
            push_ev(K_LOAD, e_cyc + 2 + 2 * j, tbl[j]);
        end
        push_ev(K_CLEAR, c_clr, '0);

        while (cyc < c_clr) begin
            step();
            i_vcounter  = '0;
            i_fifo_full = full_at[int'(cyc - c)];
            if (drop_en && cyc == c + 2) i_enable = 1'b0;
        end
        i_fifo_full = 1'b0;
        chk("busy_after_clear", o_busy, 1);

        i_drawer_waiting = 1'b0;
        if (ovr) begin
            step();
            step();
            i_vcounter = YW'(SH);
            push_ev(K_OVR, cyc + 1, '0);
            step();
            i_vcounter = '0;
        end
        while (cyc < c_clr + lwait) step();
        i_drawer_waiting = 1'b1;
        d = cyc;
        cnt_model++;
        push_ev(K_DONE, d + 1, '0);
        step();
        step();
        chk("busy_after_done", o_busy, 0);
        chk("drained", exp_q.size(), 0);

        if (drop_en) begin
            // Sequencer is now IDLE: a trigger here is a missed frame.
            i_vcounter = YW'(SH);
            push_ev(K_OVR, cyc + 1, '0);
            step();
            i_vcounter = '0;
            i_enable   = 1'b1;
            step();
            step();
            chk("drained_idle", exp_q.size(), 0);
        end
    endtask

    initial begin
        longint c;
        i_reset = 1'b1; i_enable = 1'b0; i_num_lines = '0; i_tbl_wr = 1'b0; i_tbl_addr = '0;
        i_tbl_x0 = '0; i_tbl_x1 = '0; i_tbl_y0 = '0; i_tbl_y1 = '0; i_vcounter = '0;
        i_drawer_waiting = 1'b1; i_fifo_full = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        i_reset = 1'b0;
        step();
        chk("idle_busy", o_busy, 0);
        for (int i = 0; i < int'(MAXL); i++) wr_rand();
        i_enable = 1'b1;
        step();

        wr_tbl(0, {11'd10, 11'd20, 11'd30, 11'd40});
        wr_tbl(1, {11'd639, 11'd0, 11'd479, 11'd0});
        wr_tbl(2, {11'd1, 11'd2, 11'd3, 11'd4});
        wr_tbl(3, {11'd2047, 11'd1024, 11'd5, 11'd100});
        run_frame(4, 0, -1, 1'b0, 1'b0, 50);
        run_frame(0, 0, -1, 1'b0, 1'b0, 6);
        run_frame(5, 0, 2, 1'b0, 1'b0, 10);
        run_frame(3, 0, -1, 1'b1, 1'b0, 12);
        run_frame(3, 0, -1, 1'b0, 1'b0, 8);
        run_frame(25, 0, -1, 1'b0, 1'b0, 8);
        run_frame(2, 0, -1, 1'b0, 1'b1, 8);
        for (int i = 0; i < 20; i++)
            run_frame($urandom_range(0, 31), 10, -1, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), $urandom_range(6, 20));

        // Reset while the sequencer is pushing its first segment.
        i_num_lines = 5'd4;
        i_vcounter  = YW'(SH);
        c = cyc;
        step();
        i_vcounter = '0;
        step();
        chk("busy_in_push", o_busy, 1);
        i_reset = 1'b1;
        cnt_model = 0;
        step();
        check_all_zero("midreset");
        i_reset = 1'b0;
        step();
        step();
        run_frame(3, 0, -1, 1'b0, 1'b0, 7);

        repeat (5) step();
        chk("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
